// File: rtl/nes_bus.sv
// nes_bus: CPU bus responder for the nes6502 core.
// Decodes every CPU access and serves:
//   - 2 KB work RAM ($0000-$1FFF, mirrored 4x)
//   - the PPU register window ($2000-$3FFF, mirrored every 8 bytes)
//   - the two serial joypad ports ($4016/$4017)
//   - PRG ROM ($8000-$FFFF)
// It also runs the $4014 OAM DMA engine, which halts the CPU and copies one page to PPU $2004.
// Ports:
//   clock, reset            CPU clock; asynchronous active-high reset
//   address, out, rd, we    CPU bus: address, write data, read strobe, write strobe
//   din                     read data to CPU; holds the last byte read (open bus)
//   halt                    CPU stall while DMA runs
//   prg_addr, prg_data      PRG ROM address and asynchronous data
//   ppu_cs, ppu_addr,       PPU register select, index, write strobe and write data;
//   ppu_we, ppu_wdata       ppu_rdata is the asynchronous PPU read data
//   pad1, pad2              joypad button levels (bit0 = A)
module nes_bus (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  out,
   input  logic        rd,
   input  logic        we,
   output logic [7:0]  din,
   output logic        halt,
   output logic [14:0] prg_addr,
   input  logic [7:0]  prg_data,
   output logic        ppu_cs,
   output logic [2:0]  ppu_addr,
   output logic        ppu_we,
   output logic [7:0]  ppu_wdata,
   input  logic [7:0]  ppu_rdata,
   input  logic [7:0]  pad1,
   input  logic [7:0]  pad2
);

   typedef enum logic [1:0] {StIdle, StAlign, StRead, StWrite} dma_state_e;

   dma_state_e  state_q, state_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  dbuf_q, dbuf_d;
   logic        halt_q, halt_d;
   logic        odd_q;
   logic        strobe_q;
   logic [7:0]  sr1_q, sr2_q;
   logic        rd_q;
   logic [15:0] addr_q;
   logic [7:0]  din_q;
   logic [7:0]  mem [2048];

   logic        dma_active, eff_rd, cpu_wr, new_access;
   logic [15:0] eff_addr;
   logic        ram_sel, ppu_sel, pad1_sel, pad2_sel, prg_sel;
   logic [7:0]  io_rdata;

   assign dma_active = (state_q != StIdle);
   assign eff_addr   = dma_active ? {page_q, idx_q} : address;
   assign eff_rd     = dma_active ? (state_q == StRead) : rd;
   assign cpu_wr     = we & ~dma_active;

   assign ram_sel  = (eff_addr[15:13] == 3'b000);
   assign ppu_sel  = (eff_addr[15:13] == 3'b001);
   // DMA reads of the pad ports behave as open bus and never touch the shifters
   assign pad1_sel = ~dma_active & (eff_addr == 16'h4016);
   assign pad2_sel = ~dma_active & (eff_addr == 16'h4017);
   assign prg_sel  = eff_addr[15];

   assign prg_addr = eff_addr[14:0];
   assign din      = din_q;
   assign halt     = halt_q;

   // A read is a new access when rd rises or the address moves under a held rd
   assign new_access = rd & (~rd_q | (address != addr_q));

   // Non-RAM read data; unmapped regions fall back to the held din (open bus)
   always_comb begin
      io_rdata = din_q;
      if (ppu_sel)       io_rdata = ppu_rdata;
      else if (prg_sel)  io_rdata = prg_data;
      else if (pad1_sel) io_rdata = {7'b0100000, strobe_q ? pad1[0] : sr1_q[0]};
      else if (pad2_sel) io_rdata = {7'b0100000, sr2_q[0]};
   end

   // Read path on the falling edge so data is stable at the posedge the CPU samples
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         din_q <= 8'h00;
      end else if (eff_rd) begin
         if (ram_sel) din_q <= mem[eff_addr[10:0]];
         else         din_q <= io_rdata;
      end
   end

   always_ff @(posedge clock) begin
      if (cpu_wr && ram_sel) mem[address[10:0]] <= out;
   end

   // DMA state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         page_q  <= 8'h00;
         idx_q   <= 8'h00;
         dbuf_q  <= 8'h00;
         halt_q  <= 1'b0;
         odd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         dbuf_q  <= dbuf_d;
         halt_q  <= halt_d;
         odd_q   <= ~odd_q;
      end
   end

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      idx_d   = idx_q;
      dbuf_d  = dbuf_q;
      halt_d  = halt_q;
      case (state_q)
         StIdle: begin
            if (we && (address == 16'h4014)) begin
               state_d = StAlign;
               page_d  = out;
               idx_d   = 8'h00;
               halt_d  = 1'b1;
            end
         end
         StAlign: begin
            if (odd_q) state_d = StRead;
         end
         StRead: begin
            // din_q was refreshed from {page, idx} on this cycle's falling edge
            dbuf_d  = din_q;
            state_d = StWrite;
         end
         StWrite: begin
            idx_d = idx_q + 8'd1;
            if (idx_q == 8'hFF) begin
               state_d = StIdle;
               halt_d  = 1'b0;
            end else begin
               state_d = StRead;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // PPU port: DMA owns it while active, otherwise it follows the CPU combinationally
   always_comb begin
      ppu_cs    = 1'b0;
      ppu_we    = 1'b0;
      ppu_addr  = eff_addr[2:0];
      ppu_wdata = out;
      if (state_q == StWrite) begin
         ppu_cs    = 1'b1;
         ppu_we    = 1'b1;
         ppu_addr  = 3'd4;
         ppu_wdata = dbuf_q;
      end else if (state_q == StRead) begin
         ppu_cs = ppu_sel;
      end else if (!dma_active) begin
         ppu_cs = ppu_sel & (rd | we);
         ppu_we = ppu_sel & we;
      end
   end

   // Joypad strobe and shift registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         strobe_q <= 1'b0;
         sr1_q    <= 8'hFF;
         sr2_q    <= 8'hFF;
         rd_q     <= 1'b0;
         addr_q   <= 16'h0000;
      end else begin
         rd_q   <= rd;
         addr_q <= address;
         if (cpu_wr && (address == 16'h4016)) strobe_q <= out[0];
         if (strobe_q) begin
            sr1_q <= pad1;
            sr2_q <= pad2;
         end else if (!dma_active && new_access) begin
            if (address == 16'h4016) sr1_q <= {1'b1, sr1_q[7:1]};
            if (address == 16'h4017) sr2_q <= {1'b1, sr2_q[7:1]};
         end
      end
   end

endmodule

// File: tb/tb_nes_bus.sv
module tb_nes_bus;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] address = 16'h0000;
   logic [7:0]  out = 8'h00;
   logic        rd = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  din;
   logic        halt;
   logic [14:0] prg_addr;
   logic [7:0]  prg_data = 8'h00;
   logic        ppu_cs;
   logic [2:0]  ppu_addr;
   logic        ppu_we;
   logic [7:0]  ppu_wdata;
   logic [7:0]  ppu_rdata = 8'h00;
   logic [7:0]  pad1 = 8'h00;
   logic [7:0]  pad2 = 8'h00;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   nes_bus dut (
      .clock(clock), .reset(reset), .address(address), .out(out), .rd(rd), .we(we),
      .din(din), .halt(halt), .prg_addr(prg_addr), .prg_data(prg_data),
      .ppu_cs(ppu_cs), .ppu_addr(ppu_addr), .ppu_we(ppu_we), .ppu_wdata(ppu_wdata),
      .ppu_rdata(ppu_rdata), .pad1(pad1), .pad2(pad2)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model state
   logic [7:0]  ram_m [2048];
   logic [15:0] wl[$];
   logic [7:0]  ob = 8'h00;
   bit          strobe_m = 1'b0;
   bit          sr1_m[$];
   bit          sr2_m[$];

   // Posedges since reset: the parity the DMA aligns against
   int cnt;
   always @(posedge clock or posedge reset) begin
      if (reset) cnt <= 0;
      else       cnt <= cnt + 1;
   end

   typedef struct {
      logic [7:0]  d;
      bit          is_ppu;
      logic [2:0]  pa;
      bit          is_prg;
      logic [14:0] pg;
      string       nm;
   } rexp_t;

   rexp_t      rq[$];
   logic [7:0] dq[$];
   int         dma_seen = 0;
   int         stray = 0;
   int         run = 0;
   int         last_w = 0;
   bit         w_done = 1'b0;

   // Read monitor: a read cycle ends at a posedge; inputs change at +2, so +1 still shows it
   always @(posedge clock) begin
      rexp_t e;
      #1;
      if (rd && !reset) begin
         if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL read_unexpected: got din %02h expected no read", din);
         end else begin
            e = rq.pop_front();
            check({e.nm, "_din"}, din, e.d);
            if (e.is_ppu) begin
               check({e.nm, "_ppu_cs"}, ppu_cs, 1);
               check({e.nm, "_ppu_addr"}, ppu_addr, e.pa);
            end else begin
               check({e.nm, "_ppu_cs_idle"}, ppu_cs, 0);
            end
            if (e.is_prg) check({e.nm, "_prg_addr"}, prg_addr, e.pg);
         end
      end
   end

   // PPU write monitor, sampled mid-cycle
   always @(negedge clock) begin
      logic [7:0] e;
      if (!reset && ppu_we) begin
         if (dq.size() == 0) begin
            stray++;
            checks++;
            errors++;
            $display("FAIL stray_ppu_we: got write %02h to reg %0d expected none", ppu_wdata,
                     ppu_addr);
         end else begin
            e = dq.pop_front();
            check("dma_data", ppu_wdata, e);
            check("dma_reg", ppu_addr, 4);
            dma_seen++;
         end
      end
   end

   // halt width in cycles
   always @(negedge clock) begin
      if (halt) run++;
      else if (run != 0) begin
         last_w = run;
         w_done = 1'b1;
         run = 0;
      end
   end

   task automatic do_read(input logic [15:0] a, input logic [7:0] rdv, input string nm);
      rexp_t e;
      logic  b;
      @(posedge clock); #2;
      e.d = ob; e.is_ppu = 0; e.pa = 3'd0; e.is_prg = 0; e.pg = 15'd0; e.nm = nm;
      prg_data  = rdv;
      ppu_rdata = rdv;
      if (a < 16'h2000) begin
         e.d = ram_m[a[10:0]];
      end else if (a < 16'h4000) begin
         e.d = rdv; e.is_ppu = 1; e.pa = a[2:0];
      end else if (a == 16'h4016) begin
         if (strobe_m)                b = pad1[0];
         else if (sr1_m.size() != 0)  b = sr1_m.pop_front();
         else                         b = 1'b1;
         e.d = {7'b0100000, b};
      end else if (a == 16'h4017) begin
         if (strobe_m)                b = pad2[0];
         else if (sr2_m.size() != 0)  b = sr2_m.pop_front();
         else                         b = 1'b1;
         e.d = {7'b0100000, b};
      end else if (a >= 16'h8000) begin
         e.d = rdv; e.is_prg = 1; e.pg = a[14:0];
      end
      ob = e.d;
      rq.push_back(e);
      address = a; rd = 1'b1; we = 1'b0;
      @(posedge clock); #2;
      rd = 1'b0;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d);
      @(posedge clock); #2;
      if (a < 16'h2000) begin
         ram_m[a[10:0]] = d;
         wl.push_back(a);
      end else if (a == 16'h4016) begin
         if (strobe_m && !d[0]) begin
            sr1_m.delete();
            sr2_m.delete();
            for (int i = 0; i < 8; i++) begin
               sr1_m.push_back(pad1[i]);
               sr2_m.push_back(pad2[i]);
            end
         end
         strobe_m = d[0];
      end
      address = a; out = d; we = 1'b1; rd = 1'b0;
      @(posedge clock); #2;
      we = 1'b0;
   endtask

   task automatic run_dma(input logic [7:0] pg, input int want_odd, output int meas);
      int expw;
      @(posedge clock); #2;
      if (((cnt + 1) % 2) != want_odd) begin
         @(posedge clock); #2;
      end
      for (int i = 0; i < 256; i++) dq.push_back(ram_m[{pg[2:0], i[7:0]}]);
      w_done = 1'b0;
      address = 16'h4014; out = pg; we = 1'b1; rd = 1'b0;
      @(posedge clock); #2;
      we = 1'b0;
      // 513 cycles when the alignment cycle already sees odd parity, else 514
      expw = ((cnt % 2) == 1) ? 513 : 514;
      check("halt_rise", halt, 1);
      for (int k = 0; k < 2000 && !w_done; k++) @(posedge clock);
      #2;
      if (!w_done) begin
         checks++;
         errors++;
         $display("FAIL dma_timeout: got no halt fall expected width %0d", expw);
      end
      meas = last_w;
      check("halt_width", last_w, expw);
      check("dma_remaining", dq.size(), 0);
   endtask

   initial begin
      int w0, w1, base, sel;
      logic [15:0] a;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      check("reset_din", din, 0);
      check("reset_halt", halt, 0);
      check("reset_ppu_cs", ppu_cs, 0);
      check("reset_ppu_we", ppu_we, 0);
      do_read(16'h4017, 8'h00, "reset_pad2");

      // RAM mirroring
      do_write(16'h0001, 8'h5A);
      do_read(16'h0801, 8'h00, "mirror_0801");
      do_read(16'h1801, 8'h00, "mirror_1801");

      // PPU read then open bus
      do_read(16'h2002, 8'h80, "ppu_2002");
      do_read(16'h5000, 8'h33, "openbus_5000");

      // Joypad serial read
      pad1 = 8'b0000_1001;
      pad2 = 8'hC3;
      do_write(16'h4016, 8'h01);
      do_write(16'h4016, 8'h00);
      for (int i = 0; i < 10; i++) do_read(16'h4016, 8'h00, "pad1_bit");

      // Random traffic
      pad1 = 8'($urandom);
      pad2 = 8'($urandom);
      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 7);
         case (sel)
            0: do_write(16'($urandom_range(0, 16'h1FFF)), 8'($urandom));
            1: begin
               if (wl.size() != 0) begin
                  a = wl[$urandom_range(0, wl.size() - 1)];
                  a[12:11] = 2'($urandom);
                  do_read(a, 8'($urandom), "rnd_ram");
               end else begin
                  do_read(16'h8000 | 16'($urandom_range(0, 16'h7FFF)), 8'($urandom), "rnd_prg");
               end
            end
            2: do_read(16'h2000 | 16'($urandom_range(0, 16'h1FFF)), 8'($urandom), "rnd_ppu");
            3: do_read(16'h8000 | 16'($urandom_range(0, 16'h7FFF)), 8'($urandom), "rnd_prg");
            4: begin
               if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(16'h4020, 16'h7FFF));
               else                           a = 16'($urandom_range(16'h4000, 16'h4013));
               do_read(a, 8'($urandom), "rnd_openbus");
            end
            5: do_write(16'h4016, 8'($urandom_range(0, 1)));
            6: do_read(($urandom_range(0, 1) == 0) ? 16'h4016 : 16'h4017, 8'($urandom), "rnd_pad");
            default: do_write(16'($urandom_range(16'h4020, 16'h7FFF)), 8'($urandom));
         endcase
      end

      // OAM DMA of page $03 at both parities
      for (int i = 0; i < 256; i++) do_write(16'h0300 | 16'(i), 8'(i) ^ 8'hA5);
      run_dma(8'h03, 1, w0);
      run_dma(8'h03, 0, w1);
      check("halt_width_delta", (w0 > w1) ? (w0 - w1) : (w1 - w0), 1);

      // Reset in the middle of a DMA
      base = dma_seen;
      for (int i = 0; i < 256; i++) dq.push_back(ram_m[{3'd3, i[7:0]}]);
      @(posedge clock); #2;
      address = 16'h4014; out = 8'h03; we = 1'b1;
      @(posedge clock); #2;
      we = 1'b0;
      for (int k = 0; k < 2000 && dma_seen < base + 40; k++) @(posedge clock);
      #2 reset = 1'b1;
      dq.delete();
      ob = 8'h00;
      strobe_m = 1'b0;
      sr1_m.delete();
      sr2_m.delete();
      #1;
      check("dma_writes_before_reset", dma_seen - base, 40);
      check("reset_mid_dma_halt", halt, 0);
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      repeat (600) @(posedge clock);
      #2;
      check("no_ppu_we_after_reset", stray, 0);
      check("halt_after_reset", halt, 0);
      do_read(16'h5000, 8'h77, "openbus_after_reset");
      do_read(16'h8123, 8'($urandom), "prg_8123");
      do_read(16'h4016, 8'h00, "pad1_after_reset");

      @(posedge clock); #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
